debounce: RTL and testbench
===========================

# debounce

Switch/button debouncer that sits directly downstream of `clkEn`: it consumes the one-cycle `tick` strobe as its sampling enable and produces a clean level plus single-cycle edge pulses for the decoder logic. The raw pad input is synchronized with two flops. A four-state FSM then accepts a new level only after it has held for `K` consecutive ticks.

## Interface
- `K`, default 3: number of consecutive `tick`s the synchronized input must hold before a new level is accepted. Legal range is 1 to 255.
- `CW`, default `$clog2(K)` with a minimum of 1: width of the tick counter.

- `clk`: input, 1 bit. Single system clock.
- `rst`: input, 1 bit. Asynchronous, active-high reset.
- `tick`: input, 1 bit. Sampling enable, one `clk` cycle wide, driven by `clkEn`.
- `sw`: input, 1 bit. Raw asynchronous switch or button level.
- `db_level`: output, 1 bit. Debounced level.
- `db_rise`: output, 1 bit. One-cycle pulse when a 0→1 transition is accepted.
- `db_fall`: output, 1 bit. One-cycle pulse when a 1→0 transition is accepted.

## Operation
- Synchronizer: `sw` → `s1` → `sw_sync`. Both flops reset to 0. Only `sw_sync` is used downstream.
- FSM states: ZERO, WAIT1, ONE, WAIT0. Reset state is ZERO with `cnt` = 0.
- **ZERO**
  - `sw_sync` = 1: go to WAIT1 and clear `cnt`.
  - Otherwise: stay in ZERO.
- **WAIT1**
  - `sw_sync` = 0: return to ZERO. Abort takes priority over a `tick` in the same cycle.
  - Else, on `tick` with `cnt` = K-1: go to ONE.
  - Else, on `tick`: increment `cnt`.
  - No `tick`: hold.
- **ONE**
  - `sw_sync` = 0: go to WAIT0 and clear `cnt`.
- **WAIT0**: mirror of WAIT1 with the levels swapped.
  - `sw_sync` = 1: return to ONE (abort).
  - On `tick` with `cnt` = K-1: go to ZERO.
  - On `tick` otherwise: increment `cnt`.
- `db_level` = 1 in ONE and WAIT0, and 0 in ZERO and WAIT1. A glitch never moves `db_level`.
- `db_rise` and `db_fall` are registered. Each is high for exactly the first cycle the FSM is in ONE or ZERO respectively, after arriving from WAIT1 or WAIT0.
  - Aborts never pulse.
  - Reset entry into ZERO never pulses.
- `cnt` never exceeds K-1, so there is no wrap. With K = 1 the first qualifying `tick` completes the transition.

## Timing
- Reset values: `db_level` = 0, `db_rise` = 0, `db_fall` = 0, state = ZERO, `cnt` = 0, `s1` = 0, `sw_sync` = 0.
- Reset asserted mid-wait returns to ZERO immediately and produces no pulse.
- Synchronizer latency: 2 `clk` cycles.
- A `tick` that occurs in the same cycle the FSM enters WAIT1 or WAIT0 is not counted. Counting starts on the first `tick` seen while already in the WAIT state.
- Acceptance latency, from `sw_sync` settling:
  - Minimum: K `tick`s plus 1 cycle.
  - `db_level` changes, and the edge pulse appears, in the cycle after the K-th counted `tick`.
- Consecutive accepted edges are separated by at least K `tick` periods.

## Structure
- Package `debounce_pkg`:
  - `typedef enum logic [1:0] {ZERO, WAIT1, ONE, WAIT0} db_state_t`.
  - Default `K`.
- Sub-module `sync_2ff`: two-flop synchronizer with asynchronous active-high reset to 0. It is reusable for other pad inputs.
- Top level contains the FSM, `cnt`, and the output registers. `tick` comes from an external `clkEn` instance and is not instantiated inside this block.

## Test plan
All scenarios use K = 3 and a `tick` every 4 `clk` cycles.
- **Clean press**: `sw` 0→1 held for 20 cycles → `db_level` rises in the cycle after the 3rd `tick` counted in WAIT1; `db_rise` is high for exactly 1 cycle; `db_fall` stays 0.
- **Bounce**: `sw` toggles 1,0,1,0 every 3 cycles, then holds 1 → no pulse during the bouncing; exactly one `db_rise` once 3 ticks elapse after the last toggle.
- **Glitch rejection**: `sw` = 1 for 6 cycles (2 ticks), then 0 → `db_level` stays 0; no `db_rise`; FSM returns to ZERO.
- **Release**: from the ONE state, `sw` 1→0 held → `db_fall` is a single-cycle pulse and `db_level` goes to 0 after the 3rd counted `tick`.
- **Simultaneous abort and tick**: in WAIT1 with `cnt` = 2, `sw_sync` drops in the same cycle as a `tick` → FSM goes to ZERO with no `db_rise`.
- **Reset mid-wait**: assert `rst` while in WAIT0 with `cnt` = 1 → all outputs are 0 asynchronously; after release the FSM is in ZERO and `db_fall` never pulsed.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared types and defaults for the switch debouncer.
// The FSM state encoding and the tick-counter width rule live here.
package debounce_pkg;

  typedef enum logic [1:0] {ZERO, WAIT1, ONE, WAIT0} db_state_t;

  localparam int K_DEFAULT = 3;

  // Counter width for K: $clog2(K), but never narrower than one bit.
  function automatic int cnt_width(input int k);
    if ($clog2(k) < 1) begin
      return 1;
    end else begin
      return $clog2(k);
    end
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for an asynchronous single-bit pad input.
// Both stages clear to 0 on reset.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s1_r;

  // Metastability chain: d -> s1_r -> q
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_r <= 1'b0;
      q    <= 1'b0;
    end else begin
      s1_r <= d;
      q    <= s1_r;
    end
  end

endmodule

// File: rtl/debounce.sv
// Switch debouncer: synchronizes sw, then accepts a new level only after it
// has held for K consecutive ticks. Outputs a clean level and edge pulses.
module debounce
  import debounce_pkg::*;
#(
  parameter int K  = K_DEFAULT,
  parameter int CW = cnt_width(K)
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic sw,
  output logic db_level,
  output logic db_rise,
  output logic db_fall
);

  localparam logic [CW-1:0] CNT_LAST = CW'(K - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic            sw_sync_s;
  db_state_t       state_r;
  db_state_t       state_next_s;
  logic [CW-1:0]   cnt_r;
  logic [CW-1:0]   cnt_next_s;
  logic            level_next_s;
  logic            rise_next_s;
  logic            fall_next_s;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (sw),
    .q   (sw_sync_s)
  );

  // Next-state and counter logic; an abort always beats a same-cycle tick
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    case (state_r)
      ZERO: begin
        if (sw_sync_s) begin
          state_next_s = WAIT1;
          cnt_next_s   = {CW{1'b0}};
        end else begin
          state_next_s = ZERO;
        end
      end
      WAIT1: begin
        if (!sw_sync_s) begin
          state_next_s = ZERO;
        end else if (tick) begin
          if (cnt_r == CNT_LAST) begin
            state_next_s = ONE;
          end else begin
            cnt_next_s = cnt_r + CNT_ONE;
          end
        end else begin
          state_next_s = WAIT1;
        end
      end
      ONE: begin
        if (!sw_sync_s) begin
          state_next_s = WAIT0;
          cnt_next_s   = {CW{1'b0}};
        end else begin
          state_next_s = ONE;
        end
      end
      WAIT0: begin
        if (sw_sync_s) begin
          state_next_s = ONE;
        end else if (tick) begin
          if (cnt_r == CNT_LAST) begin
            state_next_s = ZERO;
          end else begin
            cnt_next_s = cnt_r + CNT_ONE;
          end
        end else begin
          state_next_s = WAIT0;
        end
      end
      default: begin
        state_next_s = ZERO;
        cnt_next_s   = {CW{1'b0}};
      end
    endcase
  end

  // Outputs are decoded from the next state so they register alongside it
  always_comb begin
    level_next_s = (state_next_s == ONE) || (state_next_s == WAIT0);
    rise_next_s  = (state_r == WAIT1) && (state_next_s == ONE);
    fall_next_s  = (state_r == WAIT0) && (state_next_s == ZERO);
  end

  // State, counter and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= ZERO;
      cnt_r    <= {CW{1'b0}};
      db_level <= 1'b0;
      db_rise  <= 1'b0;
      db_fall  <= 1'b0;
    end else begin
      state_r  <= state_next_s;
      cnt_r    <= cnt_next_s;
      db_level <= level_next_s;
      db_rise  <= rise_next_s;
      db_fall  <= fall_next_s;
    end
  end

endmodule

// File: tb/tb_debounce.sv
// Directed bench for debounce with K = 3 and a tick every 4 clk cycles.
// Expected outputs per cycle are hand-derived from the synchronizer/FSM timing.
module tb_debounce;
  import debounce_pkg::*;

  logic clk;
  logic rst;
  logic tick;
  logic sw;
  logic db_level;
  logic db_rise;
  logic db_fall;

  int   n_vec;
  int   n_err;
  logic [1:0] ph;

  debounce #(.K(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .tick     (tick),
    .sw       (sw),
    .db_level (db_level),
    .db_rise  (db_rise),
    .db_fall  (db_fall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_st(input string tag, input db_state_t obs, input db_state_t exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %s expected %s", tag, obs.name(), exp.name());
    end
  endtask

  task automatic chk_cnt(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clk cycle: tick is high on every fourth cycle (phase 3)
  task automatic step(input logic sw_v);
    sw   = sw_v;
    tick = (ph == 2'd3);
    @(posedge clk);
    #1;
    ph = ph + 2'd1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    ph    = 2'd0;
    rst   = 1'b1;
    tick  = 1'b0;
    sw    = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk1("rst_level", db_level, 1'b0);
    chk1("rst_rise", db_rise, 1'b0);
    chk1("rst_fall", db_fall, 1'b0);
    chk_st("rst_state", dut.state_r, ZERO);
    chk_cnt("rst_cnt", dut.cnt_r, 2'd0);
    rst = 1'b0;

    // Clean press: WAIT1 after edge 2, ticks at edges 3,7,11 -> ONE at edge 11
    for (int i = 0; i < 20; i++) begin
      step(1'b1);
      chk1("press_level", db_level, i >= 11);
      chk1("press_rise", db_rise, i == 11);
      chk1("press_fall", db_fall, 1'b0);
    end
    chk_st("press_state", dut.state_r, ONE);

    // Release: mirror of the press
    for (int i = 0; i < 20; i++) begin
      step(1'b0);
      chk1("rel_level", db_level, i < 11);
      chk1("rel_fall", db_fall, i == 11);
      chk1("rel_rise", db_rise, 1'b0);
    end
    chk_st("rel_state", dut.state_r, ZERO);

    // Glitch: 6 cycles high counts two ticks, then aborts back to ZERO
    for (int i = 0; i < 12; i++) begin
      step(i < 6);
      chk1("glitch_level", db_level, 1'b0);
      chk1("glitch_rise", db_rise, 1'b0);
      if (i == 7) begin
        chk_st("glitch_wait_state", dut.state_r, WAIT1);
        chk_cnt("glitch_wait_cnt", dut.cnt_r, 2'd2);
      end
    end
    chk_st("glitch_state", dut.state_r, ZERO);

    // Abort in the same cycle as the completing tick (edge 11, cnt = 2)
    for (int i = 0; i < 16; i++) begin
      step(i < 9);
      chk1("abort_level", db_level, 1'b0);
      chk1("abort_rise", db_rise, 1'b0);
      if (i == 10) begin
        chk_st("abort_pre_state", dut.state_r, WAIT1);
        chk_cnt("abort_pre_cnt", dut.cnt_r, 2'd2);
      end
      if (i == 11) begin
        chk_st("abort_post_state", dut.state_r, ZERO);
      end
    end

    // Bounce: 1,0,1,0 for 3 cycles each, then hold 1 -> rise at edge 23
    for (int i = 0; i < 28; i++) begin
      step((i < 3) || (i >= 6 && i < 9) || (i >= 12));
      chk1("bounce_level", db_level, i >= 23);
      chk1("bounce_rise", db_rise, i == 23);
      chk1("bounce_fall", db_fall, 1'b0);
    end

    // Reset mid-wait: WAIT0 after edge 2, cnt = 1 after edge 3
    for (int i = 0; i < 5; i++) begin
      step(1'b0);
    end
    chk_st("midrst_pre_state", dut.state_r, WAIT0);
    chk_cnt("midrst_pre_cnt", dut.cnt_r, 2'd1);
    chk1("midrst_pre_level", db_level, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk1("midrst_level", db_level, 1'b0);
    chk1("midrst_rise", db_rise, 1'b0);
    chk1("midrst_fall", db_fall, 1'b0);
    chk_st("midrst_state", dut.state_r, ZERO);
    chk_cnt("midrst_cnt", dut.cnt_r, 2'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      step(1'b0);
      chk1("post_rst_level", db_level, 1'b0);
      chk1("post_rst_fall", db_fall, 1'b0);
      chk1("post_rst_rise", db_rise, 1'b0);
    end
    chk_st("post_rst_state", dut.state_r, ZERO);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
